// File: rtl/cv32e40px_pkg.sv
// Shared constants and types for the cv32e40px interrupt source unit.
// Register map, default line mask and the bus response bundle.
package cv32e40px_pkg;

  localparam logic [31:0] IRQ_MASK_DEFAULT = 32'hFFFF_0888;

  localparam logic [1:0] IRQ_GEN_ADDR_PENDING = 2'd0;
  localparam logic [1:0] IRQ_GEN_ADDR_CLEAR   = 2'd1;
  localparam logic [1:0] IRQ_GEN_ADDR_ENABLE  = 2'd2;
  localparam logic [1:0] IRQ_GEN_ADDR_MODE    = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } irq_gen_rsp_t;

  function automatic logic [31:0] irq_gen_onehot(
    input logic [4:0] id
  );
    return 32'd1 << id;
  endfunction

endpackage

// File: rtl/cv32e40px_irq_gen_sync.sv
// Two-flop synchronizer for asynchronous event lines.
// Used by cv32e40px_irq_gen when CV32E40PX_IRQ_GEN_SYNC_EN is defined.
module cv32e40px_irq_gen_sync #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cv32e40px_irq_gen.sv
// Interrupt source unit: sticky pending bits, enable mask, ack/sw clear.
// Define CV32E40PX_IRQ_GEN_SYNC_EN to synchronize event_i (asynchronous sources).
module cv32e40px_irq_gen
  import cv32e40px_pkg::*;
#(
  parameter logic [31:0] IRQ_MASK     = IRQ_MASK_DEFAULT,
  parameter logic [31:0] RESET_ENABLE = 32'h0000_0000,
  parameter logic [31:0] RESET_MODE   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] event_i,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  output logic [31:0] irq_o,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  logic [31:0] event_s;
  logic [31:0] event_q;
  logic [31:0] rise;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] enable_q;
  logic [31:0] enable_d;
  logic [31:0] mode_q;
  logic [31:0] mode_d;
  logic [31:0] irq_q;
  logic [31:0] swset;
  logic [31:0] swclr;
  logic [31:0] ackclr;
  logic [31:0] rd_mux;
  logic        wr;

  irq_gen_rsp_t rsp_q;
  irq_gen_rsp_t rsp_d;

`ifdef CV32E40PX_IRQ_GEN_SYNC_EN
  cv32e40px_irq_gen_sync #(
    .WIDTH (32)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (event_i),
    .q     (event_s)
  );
`else
  assign event_s = event_i;
`endif

  assign rise = event_s & ~event_q & IRQ_MASK;

  always_comb begin
    wr       = req_i & we_i;
    swset    = '0;
    swclr    = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    rd_mux   = '0;
    unique case (addr_i)
      IRQ_GEN_ADDR_PENDING: begin
        rd_mux = pending_q;
        if (wr) swset = wdata_i;
      end
      IRQ_GEN_ADDR_CLEAR: begin
        if (wr) swclr = wdata_i;
      end
      IRQ_GEN_ADDR_ENABLE: begin
        rd_mux = enable_q;
        if (wr) enable_d = wdata_i & IRQ_MASK;
      end
      IRQ_GEN_ADDR_MODE: begin
        rd_mux = mode_q;
        if (wr) mode_d = wdata_i & IRQ_MASK;
      end
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    ackclr = '0;
    if (irq_ack_i) ackclr = mode_q & irq_gen_onehot(irq_id_i);
    // sets are OR-ed in after the clear so they win
    pending_d = ((pending_q & ~(swclr | ackclr)) | rise | swset) & IRQ_MASK;
  end

  always_comb begin
    rsp_d.valid = req_i;
    rsp_d.data  = (req_i && !we_i) ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_q   <= '0;
      pending_q <= '0;
      enable_q  <= RESET_ENABLE & IRQ_MASK;
      mode_q    <= RESET_MODE & IRQ_MASK;
      irq_q     <= '0;
      rsp_q     <= '0;
    end else begin
      event_q   <= event_s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_q     <= pending_d & enable_d;
      rsp_q     <= rsp_d;
    end
  end

  // irq_q mirrors pending_q & enable_q from a single flop per line
  assign irq_o    = irq_q;
  assign gnt_o    = req_i & rst_n;
  assign rvalid_o = rsp_q.valid;
  assign rdata_o  = rsp_q.data;

endmodule

// File: tb/tb_cv32e40px_irq_gen.sv
// Self-checking bench for cv32e40px_irq_gen.
// Vector table plus read-data scoreboard; hand sequences for reset/latency.
module tb_cv32e40px_irq_gen;

`ifdef CV32E40PX_IRQ_GEN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int N = 26;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] event_i;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic [31:0] irq_o;
  logic        req_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  cv32e40px_irq_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .event_i   (event_i),
    .irq_ack_i (irq_ack_i),
    .irq_id_i  (irq_id_i),
    .irq_o     (irq_o),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o)
  );

  typedef struct {
    logic [31:0] ev;
    logic        ack;
    logic [4:0]  id;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] irq;
  } vec_t;

  vec_t        vt[N];
  logic [31:0] expq[$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(
    input logic [31:0] ev, input logic ack, input logic [4:0] id,
    input logic req, input logic we, input logic [1:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input logic [31:0] irq
  );
    vec_t v;
    v.ev = ev; v.ack = ack; v.id = id;
    v.req = req; v.we = we; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.irq = irq;
    return v;
  endfunction

  task automatic chk(
    input string name, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(
    input logic [31:0] ev, input logic ack, input logic [4:0] id,
    input logic req, input logic we, input logic [1:0] addr,
    input logic [31:0] wd, input logic [31:0] exp_rd
  );
    @(negedge clk);
    event_i = ev; irq_ack_i = ack; irq_id_i = id;
    req_i = req; we_i = we; addr_i = addr; wdata_i = wd;
    if (req) expq.push_back(exp_rd);
    #1;
    chk("gnt", 32'(gnt_o), 32'(req));
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rvalid_o), 32'(req));
    if (rvalid_o) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: got %h expected no response", rdata_o);
      end else begin
        chk("rdata", rdata_o, expq.pop_front());
      end
    end else if (req && expq.size() != 0) begin
      void'(expq.pop_back());
    end
  endtask

  initial begin
    int n;
    int idx;
    logic [31:0] ev;

    vt[0]  = mk(32'h0, 0, 0,  1, 1, 2, 32'h0000_0800, 0, 32'h0);
    vt[1]  = mk(32'h0000_0800, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0800);
    vt[2]  = mk(32'h0000_0800, 1, 11, 0, 0, 0, 0, 0, 32'h0);
    vt[3]  = mk(32'h0000_0800, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vt[4]  = mk(32'h0, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    vt[5]  = mk(32'h0, 0, 0,  1, 1, 3, 32'hFFFE_FFFF, 0, 32'h0);
    vt[6]  = mk(32'h0, 0, 0,  1, 1, 2, 32'h0001_0800, 0, 32'h0);
    vt[7]  = mk(32'h0001_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0001_0000);
    vt[8]  = mk(32'h0, 1, 16, 0, 0, 0, 0, 0, 32'h0001_0000);
    vt[9]  = mk(32'h0, 0, 0,  1, 0, 3, 0, 32'hFFFE_0888, 32'h0001_0000);
    vt[10] = mk(32'h0, 0, 0,  1, 1, 1, 32'h0001_0000, 0, 32'h0);
    vt[11] = mk(32'h0, 0, 0,  1, 0, 1, 0, 32'h0, 32'h0);
    vt[12] = mk(32'h0000_0008, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vt[13] = mk(32'h0, 0, 0,  1, 0, 0, 0, 32'h0000_0008, 32'h0);
    vt[14] = mk(32'h0, 0, 0,  1, 1, 2, 32'h0000_0008, 0, 32'h0000_0008);
    vt[15] = mk(32'h0, 0, 0,  1, 1, 2, 32'hFFFF_FFFF, 0, 32'h0000_0008);
    vt[16] = mk(32'h0010_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0010_0008);
    vt[17] = mk(32'h0, 0, 0,  0, 0, 0, 0, 0, 32'h0010_0008);
    vt[18] = mk(32'h0010_0000, 1, 20, 1, 1, 1, 32'h0010_0000, 0,
                32'h0010_0008);
    vt[19] = mk(32'h0, 0, 0,  1, 0, 0, 0, 32'h0010_0008, 32'h0010_0008);
    vt[20] = mk(32'h0, 0, 0,  1, 1, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_0888);
    vt[21] = mk(32'h0, 1, 0,  0, 0, 0, 0, 0, 32'hFFFF_0888);
    vt[22] = mk(32'h0, 1, 4,  0, 0, 0, 0, 0, 32'hFFFF_0888);
    vt[23] = mk(32'h0, 1, 16, 1, 0, 2, 0, 32'hFFFF_0888, 32'hFFFF_0888);
    vt[24] = mk(32'h0, 1, 31, 1, 0, 3, 0, 32'hFFFE_0888, 32'h7FFF_0888);
    vt[25] = mk(32'h0, 0, 0,  1, 0, 0, 0, 32'h7FFF_0888, 32'h7FFF_0888);

    rst_n = 1'b0;
    event_i = '0; irq_ack_i = 1'b0; irq_id_i = '0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    #12;
    chk("reset irq", irq_o, 32'h0);
    chk("reset rvalid", 32'(rvalid_o), 32'h0);
    chk("reset rdata", rdata_o, 32'h0);
    chk("reset gnt", 32'(gnt_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // events lead the table by the synchronizer depth
    for (int k = 0; k < N; k++) begin
      idx = k + LAT - 1;
      ev = (idx < N) ? vt[idx].ev : 32'h0;
      cycle(ev, vt[k].ack, vt[k].id, vt[k].req, vt[k].we,
            vt[k].addr, vt[k].wdata, vt[k].rdata);
      chk($sformatf("irq v%0d", k), irq_o, vt[k].irq);
    end

    @(negedge clk);
    event_i = '0; irq_ack_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst irq", irq_o, 32'h0);
    chk("midrst gnt", 32'(gnt_o), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst rvalid", 32'(rvalid_o), 32'h0);
    chk("midrst rdata", rdata_o, 32'h0);
    @(negedge clk);
    req_i = 1'b0;
    rst_n = 1'b1;
    expq.delete();

    cycle(32'h0, 0, 0, 1, 0, 2'd0, 0, 32'h0);
    cycle(32'h0, 0, 0, 1, 0, 2'd2, 0, 32'h0);
    cycle(32'h0, 0, 0, 1, 0, 2'd3, 0, 32'hFFFF_0888);
    cycle(32'h0, 0, 0, 1, 1, 2'd2, 32'h0000_0800, 32'h0);

    n = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(32'h0000_0800, 0, 0, 0, 0, 2'd0, 0, 32'h0);
      n++;
      if (irq_o[11]) break;
    end
    chk("latency", 32'(n), 32'(LAT));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40px_irq_gen.md
Name: cv32e40px_irq_gen

Overview:
- Interrupt source unit driving the core's 32 level-triggered irq lines.
- Converts peripheral event pulses and edges into sticky pending bits, qualifies them with a software enable mask, and presents them as the core's irq inputs.
- Clears pending bits on core acknowledge (irq_ack/irq_id) or by software write-1-to-clear.
- Sits between the peripheral event sources and the core; programmed over a small OBI-style register port.

Parameters:
- IRQ_MASK, 32'hFFFF_0888, implemented lines. Masked-out bits are never pending, never drive irq_o, and read as 0 in all registers.
- RESET_ENABLE, 32'h0000_0000, reset value of the ENABLE register.
- RESET_MODE, 32'hFFFF_FFFF, reset value of the MODE register (1 = auto-clear on ack).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- event_i  in  32  peripheral event lines; a rising edge sets pending
- irq_ack_i  in  1  core acknowledge pulse, one cycle
- irq_id_i  in  5  id of the acknowledged interrupt, valid with irq_ack_i
- irq_o  out  32  level interrupt lines to the core (= pending & enable)
- req_i  in  1  register access request
- we_i  in  1  1 = write
- addr_i  in  2  word index: 0 PENDING, 1 CLEAR, 2 ENABLE, 3 MODE
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data

Behaviour:
- Reset: all outputs 0 (irq_o, gnt_o, rvalid_o, rdata_o); pending 0; event_q 0; enable = RESET_ENABLE & IRQ_MASK; mode = RESET_MODE & IRQ_MASK.
- Edge detect: edge = event_i & ~event_q & IRQ_MASK; event_q registers event_i every cycle.
- Software set: write to PENDING sets the bits in wdata (write-1-to-set).
- Software clear: write to CLEAR clears the bits in wdata (write-1-to-clear); CLEAR reads as 0.
- Ack clear: ackclr = irq_ack_i ? (mode_q & (1 << irq_id_i)) : 0.
- Pending update: pending_d = ((pending_q & ~(swclr | ackclr)) | edge | swset) & IRQ_MASK. Any set wins over any simultaneous clear.
- irq_o = pending_q & enable_q, driven directly from flops (glitch-free).
- Latency: event rising before edge N → irq_o high after edge N, provided enable=1.
- Enable changes take effect after the write edge. Pending bits latch while disabled and assert irq_o as soon as enabled.
- Bus protocol:
  - gnt_o = req_i; no wait states.
  - Registered response: rvalid_o is high for exactly one cycle after each granted request (read or write).
  - rdata_o holds the register value sampled at the request edge; 0 for writes.
  - Back-to-back requests are allowed, one response per cycle.
- Boundary cases:
  - Ack with an id outside IRQ_MASK, or with mode bit 0: no effect.
  - event_i held high: sets pending once only; a new rising edge is required to set again.
  - Ack and new edge on the same line in the same cycle: pending stays 1.
  - Reset mid-transaction: the pending response is dropped; rvalid_o = 0.

Optional Feature:
- Macro: CV32E40PX_IRQ_GEN_SYNC_EN.
- Defined: event_i passes through a 2-flop synchronizer (reset 0) before edge detection. Edge-to-irq_o latency becomes 3 cycles. Use for asynchronous event sources.
- Undefined: event_i is assumed synchronous to clk; latency is 1 cycle.

Decomposition:
- cv32e40px_pkg: IRQ_GEN_ADDR_PENDING/CLEAR/ENABLE/MODE localparams (2'd0..2'd3). Reuse the existing IRQ_MASK default from the package.
- Sub-module cv32e40px_irq_gen_sync: parameterised-width 2-flop synchronizer, instantiated only under the macro.

Test Plan:
- event_i[11] 0→1 with enable[11]=1 → irq_o[11]=1 one cycle later. Ack with id 11 and mode=1 → irq_o[11]=0 next cycle.
- MODE=0 for line 16: event, then ack id 16 → irq_o[16] stays 1. Write CLEAR=32'h0001_0000 → irq_o[16]=0; CLEAR read returns 0.
- event_i[3] rising while enable=0 → irq_o=0. Read PENDING → 32'h0000_0008. Write ENABLE=8 → irq_o[3]=1.
- Same cycle: new edge on line 20 + ack id 20 + CLEAR bit 20 → pending[20]=1.
- Write PENDING=32'hFFFF_FFFF with ENABLE=all ones → irq_o=32'hFFFF_0888. Ack id 0 → no change.
- Read request issued then rst_n asserted before the response → rvalid_o=0, all outputs 0. With the macro defined, event-to-irq_o latency = 3 cycles.
